// File: rtl/matmul_tile_streamer.sv
// Packs an A/W element stream into zero-padded MxM tiles, runs the MatMul controller, drains C (k1 x k3); 1 beat/cycle, out_data holds while out_ready=0.
// in_ready/out_valid follow state combinationally; a WAIT watchdog is built when MM_TIMEOUT_EN is defined.
module matmul_tile_streamer #(
  parameter int M           = 3,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [7:0]         cmd_k1,
  input  logic [7:0]         cmd_k2,
  input  logic [7:0]         cmd_k3,
  input  logic               cmd_os,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [63:0]        in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [63:0]        out_data,
  output logic               out_last,
  output logic               err,
  output logic               busy,
  output logic               mm_start,
  input  logic               mm_done,
  output logic               mm_output_stationary,
  output logic [7:0]         mm_k1,
  output logic [7:0]         mm_k2,
  output logic [7:0]         mm_k3,
  output logic [64*M*M-1:0]  mm_A_tile_flat,
  output logic [64*M*M-1:0]  mm_W_tile_flat,
  input  logic [64*M*M-1:0]  mm_C_tile_flat
);

  localparam int CW = $clog2(M) + 1;
  localparam int NW = M * M;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_W = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;

  logic [2:0]          state, state_nxt;
  logic [CW-1:0]       row, col;
  logic [IW-1:0]       idx;
  logic [7:0]          row_lim, col_lim;
  logic                row_end, col_end, advance, cmd_bad, timeout;
  logic [NW-1:0][63:0] a_tile, w_tile, c_buf;

  assign in_ready  = (state == S_LOAD_A) || (state == S_LOAD_W);
  assign out_valid = (state == S_DRAIN);
  assign busy      = (state != S_IDLE);
  assign mm_start  = (state == S_START);

  // The same row/col walker serves A load, W load and C drain; only the bounds change.
  assign col_lim  = (state == S_LOAD_A) ? mm_k2 : mm_k3;
  assign row_lim  = (state == S_LOAD_W) ? mm_k2 : mm_k1;
  assign col_end  = (8'(col) == col_lim - 8'd1);
  assign row_end  = (8'(row) == row_lim - 8'd1);
  assign idx      = IW'(int'(row) * M + int'(col));
  assign advance  = (in_valid && in_ready) || (out_valid && out_ready);
  assign out_last = out_valid && row_end && col_end;
  assign out_data = c_buf[idx];

  assign mm_A_tile_flat = a_tile;
  assign mm_W_tile_flat = w_tile;

  assign cmd_bad = (cmd_k1 == 8'd0) || (cmd_k2 == 8'd0) || (cmd_k3 == 8'd0) ||
                   (cmd_k1 > 8'(M)) || (cmd_k2 > 8'(M)) || (cmd_k3 > 8'(M));

`ifdef MM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wait_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               wait_cnt <= '0;
    else if (state != S_WAIT)   wait_cnt <= '0;
    else                        wait_cnt <= wait_cnt + TW'(1);
  end

  assign timeout = (state == S_WAIT) && !mm_done && (wait_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (cmd_valid && cmd_ready && !cmd_bad) state_nxt = S_LOAD_A;
      S_LOAD_A: if (in_valid && row_end && col_end)     state_nxt = S_LOAD_W;
      S_LOAD_W: if (in_valid && row_end && col_end)     state_nxt = S_START;
      S_START:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (mm_done)      state_nxt = S_DRAIN;
        else if (timeout) state_nxt = S_IDLE;
      end
      S_DRAIN:  if (out_ready && row_end && col_end)    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + CW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // cmd_ready is a flop so it reads 0 while reset is held, then rises the cycle after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                <= S_IDLE;
      cmd_ready            <= 1'b0;
      err                  <= 1'b0;
      mm_k1                <= '0;
      mm_k2                <= '0;
      mm_k3                <= '0;
      mm_output_stationary <= 1'b0;
      a_tile               <= '0;
      w_tile               <= '0;
      c_buf                <= '0;
    end else begin
      state     <= state_nxt;
      cmd_ready <= (state_nxt == S_IDLE);
      err       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            if (cmd_bad) begin
              err <= 1'b1;
            end else begin
              mm_k1                <= cmd_k1;
              mm_k2                <= cmd_k2;
              mm_k3                <= cmd_k3;
              mm_output_stationary <= cmd_os;
              a_tile               <= '0;
              w_tile               <= '0;
            end
          end
        end
        S_LOAD_A: if (in_valid) a_tile[idx] <= in_data;
        S_LOAD_W: if (in_valid) w_tile[idx] <= in_data;
        S_WAIT: begin
          if (mm_done)      c_buf <= mm_C_tile_flat;
          else if (timeout) err   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_tile_streamer.sv
// Bench for matmul_tile_streamer: a behavioural controller stub multiplies the presented tiles,
// and a matrix-level reference model predicts tiles and the drained C stream.
module tb_matmul_tile_streamer;
  localparam int M  = 3;
  localparam int TO = 64;

  logic              clk;
  logic              reset_n;
  logic              cmd_valid, cmd_ready, cmd_os;
  logic [7:0]        cmd_k1, cmd_k2, cmd_k3;
  logic              in_valid, in_ready;
  logic [63:0]       in_data;
  logic              out_valid, out_ready, out_last;
  logic [63:0]       out_data;
  logic              err, busy, mm_start, mm_done, mm_output_stationary;
  logic [7:0]        mm_k1, mm_k2, mm_k3;
  logic [64*M*M-1:0] mm_A_tile_flat, mm_W_tile_flat, mm_C_tile_flat;

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  int err_cnt = 0;
  bit stub_en = 1'b1;
  int stub_delay = 2;
  logic [63:0] exp_a [M*M];
  logic [63:0] exp_w [M*M];

  matmul_tile_streamer #(.M(M), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_k1(cmd_k1), .cmd_k2(cmd_k2), .cmd_k3(cmd_k3), .cmd_os(cmd_os),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .err(err), .busy(busy), .mm_start(mm_start), .mm_done(mm_done),
    .mm_output_stationary(mm_output_stationary),
    .mm_k1(mm_k1), .mm_k2(mm_k2), .mm_k3(mm_k3),
    .mm_A_tile_flat(mm_A_tile_flat), .mm_W_tile_flat(mm_W_tile_flat),
    .mm_C_tile_flat(mm_C_tile_flat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mm_start === 1'b1) start_cnt++;
    if (err === 1'b1) err_cnt++;
  end

  // Controller stub: drops done on start, then after a delay presents A*W over the full padded tile.
  initial begin
    mm_done = 1'b0;
    mm_C_tile_flat = '0;
    forever begin
      @(negedge clk);
      if (!stub_en) mm_done = 1'b0;
      else if (mm_start === 1'b1) begin
        mm_done = 1'b0;
        repeat (stub_delay) @(negedge clk);
        for (int r = 0; r < M; r++)
          for (int c = 0; c < M; c++) begin
            real s;
            s = 0.0;
            for (int j = 0; j < M; j++)
              s += $bitstoreal(mm_A_tile_flat[64*(r*M+j) +: 64]) * $bitstoreal(mm_W_tile_flat[64*(j*M+c) +: 64]);
            mm_C_tile_flat[64*(r*M+c) +: 64] = $realtobits(s);
          end
        mm_done = 1'b1;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL global_watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic send_cmd(input int k1, input int k2, input int k3, input bit os);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_k1 = 8'(k1); cmd_k2 = 8'(k2); cmd_k3 = 8'(k3); cmd_os = os;
    while (cmd_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n >= 20) begin failures++; $display("FAIL cmd_accept: cmd_ready never rose (got %b, required 1)", cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic send_elem(input logic [63:0] d);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d;
    while (in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n >= 20) begin failures++; $display("FAIL in_accept: in_ready never rose (got %b, required 1)", in_ready); end
    @(negedge clk);
  endtask

  task automatic run_op(input string nm, input int k1, input int k2, input int k3, input bit os,
                        input real a[M*M], input real w[M*M], input int rmode, input bit noisy);
    logic [63:0] exp_out[$];
    logic [63:0] prev_d, e;
    int s0, e0, cyc, beats, size;
    bit done, prev_stall, mism;
    real s;
    for (int i = 0; i < M*M; i++) begin exp_a[i] = '0; exp_w[i] = '0; end
    for (int r = 0; r < k1; r++) for (int c = 0; c < k2; c++) exp_a[r*M+c] = $realtobits(a[r*k2+c]);
    for (int r = 0; r < k2; r++) for (int c = 0; c < k3; c++) exp_w[r*M+c] = $realtobits(w[r*k3+c]);
    for (int r = 0; r < k1; r++)
      for (int c = 0; c < k3; c++) begin
        s = 0.0;
        for (int j = 0; j < k2; j++) s += a[r*k2+j] * w[j*k3+c];
        exp_out.push_back($realtobits(s));
      end
    size = k1 * k3;
    s0 = start_cnt; e0 = err_cnt;
    stub_delay = $urandom_range(1, 5);

    send_cmd(k1, k2, k3, os);
    for (int i = 0; i < k1*k2; i++) begin
      if (noisy && $urandom_range(0, 3) == 0) begin in_valid = 1'b0; @(negedge clk); end
      send_elem($realtobits(a[i]));
    end
    for (int i = 0; i < k2*k3; i++) begin
      if (noisy && $urandom_range(0, 3) == 0) begin in_valid = 1'b0; @(negedge clk); end
      send_elem($realtobits(w[i]));
    end
    in_valid = 1'b0;
    // A bad command offered while busy must be ignored, not queued.
    if (noisy) begin cmd_valid = 1'b1; cmd_k1 = 8'd0; cmd_k2 = 8'd9; cmd_k3 = 8'd0; end

    cyc = 0; done = 1'b0; prev_stall = 1'b0; beats = 0; prev_d = '0;
    while (!done && cyc < 400) begin
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid === 1'b1) begin
        if (prev_stall) begin
          checks++;
          if (out_data !== prev_d) begin failures++; $display("FAIL %s stall_hold: out_data %h, required held %h", nm, out_data, prev_d); end
        end
        if (out_ready) begin
          e = (beats < size) ? exp_out[beats] : 64'hx;
          checks++;
          if (beats >= size || out_data !== e) begin
            failures++; $display("FAIL %s data beat %0d: got %h, required %h", nm, beats, out_data, e);
          end
          checks++;
          if (out_last !== (beats == size - 1)) begin
            failures++; $display("FAIL %s last beat %0d: got %b, required %b", nm, beats, out_last, (beats == size - 1));
          end
          if (out_last === 1'b1 || beats >= size) done = 1'b1;
          beats++;
        end
        prev_stall = !out_ready;
        prev_d = out_data;
      end else begin
        prev_stall = 1'b0;
      end
      if (done) cmd_valid = 1'b0;
      else begin @(negedge clk); cyc++; end
    end
    cmd_valid = 1'b0;
    checks++;
    if (!done) begin failures++; $display("FAIL %s drain_timeout: beats %0d, required %0d", nm, beats, size); end
    checks++;
    if (beats != size) begin failures++; $display("FAIL %s beat_count: got %0d, required %0d", nm, beats, size); end
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL %s idle_after: busy=%b out_valid=%b, required 0 0", nm, busy, out_valid);
    end
    checks++;
    if (start_cnt - s0 != 1) begin failures++; $display("FAIL %s start_pulses: got %0d, required 1", nm, start_cnt - s0); end
    checks++;
    if (err_cnt != e0) begin failures++; $display("FAIL %s err_pulses: got %0d, required 0", nm, err_cnt - e0); end
    checks++;
    if ({mm_k1, mm_k2, mm_k3, mm_output_stationary} !== {8'(k1), 8'(k2), 8'(k3), os}) begin
      failures++; $display("FAIL %s dims: got %0d %0d %0d os=%b, required %0d %0d %0d os=%b",
                           nm, mm_k1, mm_k2, mm_k3, mm_output_stationary, k1, k2, k3, os);
    end
    mism = 1'b0;
    for (int i = 0; i < M*M; i++)
      if (mm_A_tile_flat[64*i +: 64] !== exp_a[i] || mm_W_tile_flat[64*i +: 64] !== exp_w[i]) mism = 1'b1;
    checks++;
    if (mism) begin failures++; $display("FAIL %s tiles: A=%h W=%h do not match padded model", nm, mm_A_tile_flat, mm_W_tile_flat); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cmd_valid = 1'b0; cmd_k1 = '0; cmd_k2 = '0; cmd_k3 = '0; cmd_os = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    checks++;
    if ({cmd_ready, in_ready, out_valid, out_last, err, busy, mm_start, mm_output_stationary} !== 8'b0) begin
      failures++; $display("FAIL reset_ctrl: got %b, required 00000000",
                           {cmd_ready, in_ready, out_valid, out_last, err, busy, mm_start, mm_output_stationary});
    end
    checks++;
    if ({mm_k1, mm_k2, mm_k3} !== 24'd0 || out_data !== 64'd0) begin
      failures++; $display("FAIL reset_dims: k=%h out_data=%h, required 0", {mm_k1, mm_k2, mm_k3}, out_data);
    end
    checks++;
    if (mm_A_tile_flat !== '0 || mm_W_tile_flat !== '0) begin
      failures++; $display("FAIL reset_tiles: A=%h W=%h, required 0", mm_A_tile_flat, mm_W_tile_flat);
    end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL post_reset_idle: cmd_ready=%b busy=%b, required 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_spec_cases();
    real a[M*M];
    real w[M*M];
    a = '{1.0, 2.0, 3.0, 4.0, 5.0, 6.0, 7.0, 8.0, 9.0};
    w = '{1.0, 0.0, 0.0, 0.0, 1.0, 0.0, 0.0, 0.0, 1.0};
    run_op("ws_3x3_identity", 3, 3, 3, 1'b0, a, w, 0, 1'b0);
    a = '{1.0, 2.0, 3.0, 4.0, 5.0, 6.0, 0.0, 0.0, 0.0};
    w = '{1.0, 2.0, 3.0, 4.0, 5.0, 6.0, 0.0, 0.0, 0.0};
    run_op("ws_2x3x2", 2, 3, 2, 1'b0, a, w, 0, 1'b0);
    a = '{1.0, 2.0, 3.0, 4.0, 5.0, 6.0, 7.0, 8.0, 9.0};
    w = '{1.0, 0.0, 0.0, 0.0, 1.0, 0.0, 0.0, 0.0, 1.0};
    run_op("os_3x3_toggle_ready", 3, 3, 3, 1'b1, a, w, 1, 1'b0);
    a = '{5.0, 0.0, 0.0, 0.0, 0.0, 0.0, 0.0, 0.0, 0.0};
    w = '{7.0, 0.0, 0.0, 0.0, 0.0, 0.0, 0.0, 0.0, 0.0};
    run_op("single_1x1", 1, 1, 1, 1'b0, a, w, 0, 1'b0);
  endtask

  task automatic test_bad_cmd();
    int s0;
    bit mism;
    logic [7:0] bad [2][3];
    bad[0] = '{8'd0, 8'd2, 8'd2};
    bad[1] = '{8'd2, 8'd4, 8'd2};
    s0 = start_cnt;
    for (int t = 0; t < 2; t++) begin
      cmd_valid = 1'b1; cmd_k1 = bad[t][0]; cmd_k2 = bad[t][1]; cmd_k3 = bad[t][2]; cmd_os = 1'b1;
      checks++;
      if (cmd_ready !== 1'b1) begin failures++; $display("FAIL bad_cmd%0d ready_before: got %b, required 1", t, cmd_ready); end
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
        failures++; $display("FAIL bad_cmd%0d pulse: err=%b busy=%b cmd_ready=%b, required 1 0 1", t, err, busy, cmd_ready);
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b0) begin failures++; $display("FAIL bad_cmd%0d pulse_width: err=%b, required 0", t, err); end
    end
    checks++;
    if (start_cnt != s0) begin failures++; $display("FAIL bad_cmd no_start: got %0d pulses, required 0", start_cnt - s0); end
    mism = 1'b0;
    for (int i = 0; i < M*M; i++)
      if (mm_A_tile_flat[64*i +: 64] !== exp_a[i] || mm_W_tile_flat[64*i +: 64] !== exp_w[i]) mism = 1'b1;
    checks++;
    if (mism || mm_k1 !== 8'd1 || mm_output_stationary !== 1'b0) begin
      failures++; $display("FAIL bad_cmd tiles_kept: k1=%0d os=%b, required previous op state (k1=1 os=0)", mm_k1, mm_output_stationary);
    end
  endtask

  task automatic test_reset_midop();
    real a[M*M];
    real w[M*M];
    send_cmd(3, 3, 3, 1'b1);
    for (int i = 0; i < 9; i++) send_elem($realtobits(real'(i + 1)));
    for (int i = 0; i < 2; i++) send_elem($realtobits(real'(i + 2)));
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, in_ready, out_valid, err, busy, mm_start, mm_output_stationary} !== 7'b0 ||
        {mm_k1, mm_k2, mm_k3} !== 24'd0 || mm_A_tile_flat !== '0 || mm_W_tile_flat !== '0) begin
      failures++; $display("FAIL midop_reset: busy=%b in_ready=%b k1=%0d A=%h, required all 0", busy, in_ready, mm_k1, mm_A_tile_flat);
    end
    in_valid = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    a = '{1.0, 2.0, 3.0, 4.0, 0.0, 0.0, 0.0, 0.0, 0.0};
    w = '{2.0, 3.0, 4.0, 5.0, 0.0, 0.0, 0.0, 0.0, 0.0};
    run_op("after_reset_2x2", 2, 2, 2, 1'b0, a, w, 0, 1'b0);
  endtask

  task automatic test_random_back_to_back();
    real a[M*M];
    real w[M*M];
    int k1, k2, k3;
    for (int it = 0; it < 25; it++) begin
      k1 = $urandom_range(1, M); k2 = $urandom_range(1, M); k3 = $urandom_range(1, M);
      for (int i = 0; i < M*M; i++) begin
        a[i] = real'($urandom_range(0, 31)) - 8.0;
        w[i] = real'($urandom_range(0, 31)) * 0.5;
      end
      run_op($sformatf("rand%0d", it), k1, k2, k3, 1'($urandom_range(0, 1)), a, w, 2, 1'b1);
    end
  endtask

`ifdef MM_TIMEOUT_EN
  task automatic test_timeout();
    int n, e0;
    bit saw_valid;
    stub_en = 1'b0;
    @(negedge clk);
    e0 = err_cnt;
    send_cmd(1, 1, 1, 1'b0);
    send_elem($realtobits(3.0));
    send_elem($realtobits(4.0));
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0; saw_valid = 1'b0;
    while (err !== 1'b1 && n < TO + 50) begin
      @(negedge clk); n++;
      if (out_valid === 1'b1) saw_valid = 1'b1;
    end
    checks++;
    if (n < TO - 2 || n > TO + 3) begin failures++; $display("FAIL timeout_cycles: err after %0d cycles, required about %0d", n, TO); end
    checks++;
    if (saw_valid || busy !== 1'b0) begin failures++; $display("FAIL timeout_idle: out_valid seen=%b busy=%b, required 0 0", saw_valid, busy); end
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (err_cnt - e0 != 1 || cmd_ready !== 1'b1) begin
      failures++; $display("FAIL timeout_pulse: pulses=%0d cmd_ready=%b, required 1 1", err_cnt - e0, cmd_ready);
    end
    stub_en = 1'b1;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_spec_cases();
    test_bad_cmd();
    test_reset_midop();
    test_random_back_to_back();
`ifdef MM_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
